// File: rtl/spi_req_arbiter_pkg.sv
// spi_pkg: shared FSM states, requester count and default chip-select timing
package spi_pkg;
  localparam int N_REQ = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD = 2;
  localparam int DEF_CS_GAP = 1;
  localparam int DEF_TIMEOUT = 64;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if: requester handshake, response and SPI engine bus
// ports: req_valid/req_data/req_ready, rsp_valid/rsp_data/rsp_err, eng_start/eng_tx/eng_done/eng_rx, ss_n, busy
interface spi_req_arbiter_if #(parameter int N = spi_pkg::N_REQ);
  logic [N-1:0] req_valid, req_ready, rsp_valid, ss_n;
  logic [8*N-1:0] req_data;
  logic [7:0] rsp_data, eng_tx, eng_rx;
  logic rsp_err, eng_start, eng_done, busy;
  modport slave(input req_valid, req_data, eng_done, eng_rx, output req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_tx, ss_n, busy);
  modport master(output req_valid, req_data, eng_done, eng_rx, input req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_tx, ss_n, busy);
endinterface

// File: rtl/spi_req_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first request at or after the pointer
// ports: clk, rst, req_i, accept_i (advance pointer past grant), gnt_o one-hot, idx_o binary, any_o
module rr_arbiter import spi_pkg::*; #(
  parameter int N = N_REQ,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [W-1:0] ptr_q, ptr_d, j;
  // scanned from the far end so the nearest request to the pointer is written last
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr_q) + i) % N);
      if (req_i[j]) begin
        idx_o = j;
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
  assign ptr_d = accept_i ? (idx_o == W'(N - 1) ? '0 : idx_o + 1'b1) : ptr_q;
  always_ff @(posedge clk)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin SPI transaction scheduler with chip-select sequencing and timeout
// ports: clk, rst (sync, active high), bus (slave modport of spi_req_arbiter_if)
module spi_req_arbiter import spi_pkg::*; #(
  parameter int N_REQ = spi_pkg::N_REQ,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD = DEF_CS_HOLD,
  parameter int CS_GAP = DEF_CS_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  spi_req_arbiter_if.slave bus
);
  localparam int W = $clog2(N_REQ);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0] g_q, g_d, idx;
  logic [7:0] tx_q, tx_d, rx_q, rx_d;
  logic err_q, err_d;
  logic [N_REQ-1:0] gnt;
  logic req_any, accept, first_hold;
  rr_arbiter #(.N(N_REQ), .W(W)) u_arb (
    .clk(clk), .rst(rst), .req_i(bus.req_valid), .accept_i(accept),
    .gnt_o(gnt), .idx_o(idx), .any_o(req_any)
  );
  assign accept = state_q == IDLE && req_any;
  // the shared counter is reloaded to CS_HOLD-1 on entry, so this marks the first HOLD cycle
  assign first_hold = state_q == HOLD && cnt_q == CNT_W'(CS_HOLD - 1);
  assign bus.req_ready = accept ? gnt : '0;
  assign bus.ss_n = state_q inside {SETUP, START, WAIT, HOLD} ? ~(N_REQ'(1) << g_q) : '1;
  assign bus.rsp_valid = first_hold ? N_REQ'(1) << g_q : '0;
  assign bus.rsp_data = rx_q;
  assign bus.rsp_err = first_hold & err_q;
  assign bus.eng_start = state_q == START;
  assign bus.eng_tx = tx_q;
  assign bus.busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - 1'b1;
    g_d = g_q;
    tx_d = tx_q;
    rx_d = rx_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_any) begin
        state_d = SETUP;
        cnt_d = CNT_W'(CS_SETUP - 1);
        g_d = idx;
        tx_d = bus.req_data[{idx, 3'b000} +: 8];
      end
      SETUP: if (cnt_q == '0) state_d = START;
      START: begin
        state_d = WAIT;
        cnt_d = CNT_W'(TIMEOUT - 1);
      end
      // a completion on the last allowed cycle still wins over the timeout
      WAIT: if (bus.eng_done || cnt_q == '0) begin
        state_d = HOLD;
        cnt_d = CNT_W'(CS_HOLD - 1);
        rx_d = bus.eng_done ? bus.eng_rx : 8'h00;
        err_d = !bus.eng_done;
      end
      HOLD: if (cnt_q == '0) begin
        state_d = GAP;
        cnt_d = CNT_W'(CS_GAP - 1);
      end
      GAP: if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      g_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      g_q <= g_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: table vectors, directed corner sequences and a randomized transaction-level model
module tb_spi_req_arbiter;
  localparam int N = 4, CSS = 2, CSH = 2, CSG = 1, TMO = 64, S = CSS + 1;
  typedef struct {
    logic [3:0] v;
    logic [7:0] d, rx;
    int dly;
    bit stray;
    int g;
    bit err;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0;
  bit m_act = 0, m_err = 0;
  int m_k = 0, m_d = -1, m_g = 0, m_ptr = 0, m_last = -1;
  logic [7:0] m_tx = 0, m_rx = 0;
  vec_t tbl[8];
  spi_req_arbiter_if #(.N(N)) bus();
  spi_req_arbiter #(.N_REQ(N), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_GAP(CSG), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [31:0] lanes(input logic [7:0] d);
    logic [31:0] r;
    for (int i = 0; i < N; i++) r[8*i +: 8] = d ^ 8'(i * 8'h11);
    return r;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.eng_done = 0;
    bus.eng_rx = '0;
    @(negedge clk);
    rst = 0;
    m_act = 0;
    m_ptr = 0;
    m_last = -1;
  endtask
  task automatic run_txn(input vec_t t);
    logic [3:0] oh = 4'(1) << t.g;
    logic [3:0] noh = ~oh;
    logic [7:0] tx = t.d ^ 8'(t.g * 8'h11);
    @(negedge clk);
    bus.req_valid = t.v;
    bus.req_data = lanes(t.d);
    #1 chk("grant", bus.req_ready, oh);
    @(negedge clk);
    bus.req_valid = '0;
    bus.eng_done = t.stray;
    bus.eng_rx = 8'hBD;
    #1 chk("ss_fall", bus.ss_n, noh);
    chk("busy_setup", bus.busy, 1);
    @(negedge clk);
    bus.eng_done = 0;
    repeat (CSS - 1) @(negedge clk);
    #1 chk("eng_start", bus.eng_start, 1);
    chk("eng_tx", bus.eng_tx, tx);
    if (t.dly > 0) begin
      repeat (t.dly - 1) @(negedge clk);
      @(negedge clk);
      bus.eng_done = 1;
      bus.eng_rx = t.rx;
    end else repeat (TMO) @(negedge clk);
    #1 chk("wait_no_rsp", bus.rsp_valid, 0);
    chk("tx_stable", bus.eng_tx, tx);
    chk("ss_wait", bus.ss_n, noh);
    @(negedge clk);
    bus.eng_done = 0;
    bus.eng_rx = '0;
    #1 chk("rsp_valid", bus.rsp_valid, oh);
    chk("rsp_data", bus.rsp_data, t.err ? 8'h00 : t.rx);
    chk("rsp_err", bus.rsp_err, t.err);
    repeat (CSH - 1) @(negedge clk);
    #1 chk("ss_hold", bus.ss_n, noh);
    chk("rsp_once", bus.rsp_valid, 0);
    @(negedge clk);
    #1 chk("ss_rise", bus.ss_n, 4'hF);
    chk("busy_gap", bus.busy, 1);
    repeat (CSG) @(negedge clk);
    #1 chk("idle", bus.busy, 0);
  endtask
  // transaction-level reference: everything is timed relative to the grant cycle (k=0)
  task automatic model_cycle(input logic [3:0] v, input logic [31:0] d, input logic dn, input logic [7:0] rxb);
    logic [3:0] e_ready = '0, e_ss = 4'hF, e_rsp = '0;
    logic e_start = 0, e_busy = 0;
    int pick = -1;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data = d;
    bus.eng_done = dn;
    bus.eng_rx = rxb;
    #1;
    if (!m_act) begin
      for (int i = 0; i < N && pick < 0; i++) if (v[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
      if (pick >= 0) e_ready = 4'(1) << pick;
    end else begin
      e_busy = 1;
      if (m_d < 0 || m_k <= m_d + CSH) e_ss = ~(4'(1) << m_g);
      e_start = m_k == S;
      if (m_d >= 0 && m_k == m_d + 1) e_rsp = 4'(1) << m_g;
      if (m_k >= S && (m_d < 0 || m_k <= m_d)) chk("m_eng_tx", bus.eng_tx, m_tx);
    end
    chk("m_req_ready", bus.req_ready, e_ready);
    chk("m_ss_n", bus.ss_n, e_ss);
    chk("m_busy", bus.busy, e_busy);
    chk("m_eng_start", bus.eng_start, e_start);
    chk("m_rsp_valid", bus.rsp_valid, e_rsp);
    if (e_rsp != 0) begin
      chk("m_rsp_data", bus.rsp_data, m_rx);
      chk("m_rsp_err", bus.rsp_err, m_err);
    end
    m_last = -1;
    if (!m_act && pick >= 0) begin
      m_act = 1;
      m_k = 0;
      m_d = -1;
      m_g = pick;
      m_tx = d[8*pick +: 8];
      m_ptr = (pick + 1) % N;
      m_last = pick;
    end else if (m_act && m_d < 0 && m_k > S) begin
      if (dn) begin
        m_d = m_k;
        m_rx = rxb;
        m_err = 0;
      end else if (m_k == S + TMO) begin
        m_d = m_k;
        m_rx = 8'h00;
        m_err = 1;
      end
    end
    if (m_act) begin
      m_k++;
      if (m_d >= 0 && m_k == m_d + 1 + CSH + CSG) m_act = 0;
    end
  endtask
  task automatic contention();
    int order[$];
    int exp_o[5] = '{0, 1, 2, 3, 0};
    int run = 0;
    bit seen_low = 0;
    logic [3:0] prev = 4'hF;
    do_reset();
    for (int c = 0; c < 1000 && order.size() < 5; c++) begin
      model_cycle(4'hF, lanes(8'(c)), 1'($urandom_range(0, 1)), 8'($urandom));
      if (bus.req_ready != 0) order.push_back($clog2(bus.req_ready));
      chk("one_low", $countones(~bus.ss_n) <= 1, 1);
      if (bus.ss_n == 4'hF) run++;
      else begin
        if (prev == 4'hF && seen_low) chk("cs_gap", run >= CSG, 1);
        if (prev != 4'hF) chk("ss_switch", bus.ss_n, prev);
        seen_low = 1;
        run = 0;
      end
      prev = bus.ss_n;
    end
    chk("order_count", order.size() >= 5, 1);
    if (order.size() >= 5) for (int i = 0; i < 5; i++) chk("order", order[i], exp_o[i]);
  endtask
  task automatic random_run(input int cycles);
    logic [3:0] pend = '0;
    logic [31:0] dat = '0;
    int prob = 30;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      if (c % 150 == 0) prob = ((c / 150) % 3 == 1) ? 0 : int'($urandom_range(10, 60));
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 99) < 25) begin
          pend[i] = 1;
          dat[8*i +: 8] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 99) < 2) pend[i] = 0;
      model_cycle(pend, dat, $urandom_range(0, 99) < prob, 8'($urandom));
      if (m_last >= 0) pend[m_last] = 0;
    end
  endtask
  initial begin
    tbl[0] = '{4'b0010, 8'hA5, 8'h3C, 5, 0, 1, 0};
    tbl[1] = '{4'b1111, 8'h5A, 8'hC3, 1, 1, 2, 0};
    tbl[2] = '{4'b0101, 8'h11, 8'h22, 3, 0, 0, 0};
    tbl[3] = '{4'b0101, 8'h33, 8'h44, 2, 0, 2, 0};
    tbl[4] = '{4'b1000, 8'h66, 8'h77, 4, 0, 3, 0};
    tbl[5] = '{4'b1000, 8'h88, 8'h99, 2, 0, 3, 0};
    tbl[6] = '{4'b0001, 8'hF0, 8'hEE, -1, 0, 0, 1};
    tbl[7] = '{4'b1001, 8'h0F, 8'h55, TMO, 0, 3, 0};
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.eng_done = 0;
    bus.eng_rx = '0;
    do_reset();
    #1 chk("rst_ss_n", bus.ss_n, 4'hF);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    chk("rst_eng_tx", bus.eng_tx, 8'h00);
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_data = lanes(8'h12);
    #1 chk("r_grant", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (CSS + 1) @(negedge clk);
    #1 chk("r_busy_wait", bus.busy, 1);
    rst = 1;
    bus.eng_done = 1;
    bus.eng_rx = 8'h77;
    @(negedge clk);
    rst = 0;
    bus.eng_done = 0;
    bus.req_valid = 4'hF;
    #1 chk("r_ss_n", bus.ss_n, 4'hF);
    chk("r_busy", bus.busy, 0);
    chk("r_rsp_valid", bus.rsp_valid, 0);
    chk("r_ptr", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("r_no_rsp", bus.rsp_valid, 0);
    contention();
    random_run(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin transaction scheduler that shares one byte-level SPI master engine between four requesters. Requester *i* always targets slave *i*. The block grants one requester at a time and drives the active-low slave selects with programmable setup and hold times. It launches the engine, collects the received byte and returns it to the granted requester, with a timeout guarding a stalled engine. It sits between the requester logic and the SPI master/slave datapath and owns all chip-select sequencing.

## Interface
Parameters:
- N_REQ, 4: number of requesters; one slave select per requester.
- CS_SETUP, 2: cycles `ss_n` is low before `eng_start`; minimum 1.
- CS_HOLD, 2: cycles `ss_n` stays low after `eng_done`; minimum 1.
- CS_GAP, 1: cycles all selects are high between transactions; minimum 1.
- TIMEOUT, 64: maximum cycles in WAIT before abort.

Ports:
- clk, in, 1: single clock. All logic is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, N_REQ: request pending, one bit per requester. Held until accepted.
- req_data, in, 8*N_REQ: transmit byte. Requester *i* uses bits [8i+7:8i].
- req_ready, out, N_REQ: one-hot, one-cycle accept pulse.
- rsp_valid, out, N_REQ: one-hot, one-cycle response pulse.
- rsp_data, out, 8: received byte. Valid only while `rsp_valid` is nonzero.
- rsp_err, out, 1: timeout flag. Qualified by `rsp_valid`.
- eng_start, out, 1: one-cycle launch pulse to the engine.
- eng_tx, out, 8: byte for the engine. Stable from `eng_start` until `eng_done`.
- eng_done, in, 1: engine completion pulse.
- eng_rx, in, 8: engine received byte. Valid with `eng_done`.
- ss_n, out, N_REQ: active-low slave selects. At most one bit low at any time.
- busy, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, SETUP, START, WAIT, HOLD, GAP.
- IDLE, with any `req_valid` set:
  - Grant the first set bit at or after `rr_ptr`, wrapping modulo N_REQ.
  - Pulse `req_ready[g]` in this same cycle.
  - Latch g and `req_data[g]`.
  - Set `rr_ptr` to g+1 (wraps 3→0).
  - Go to SETUP.
- SETUP: `ss_n[g]` is low. Count CS_SETUP cycles, then go to START.
- START: `eng_start`=1 for exactly one cycle; `eng_tx` holds the latched byte. Go to WAIT.
- WAIT:
  - On `eng_done`: capture `eng_rx`, clear the error flag, go to HOLD.
  - If the cycle counter reaches TIMEOUT first: capture 8'h00, set the error flag, go to HOLD.
  - `eng_done` outside WAIT is ignored.
- HOLD:
  - In the first HOLD cycle, `rsp_valid[g]`=1 and `rsp_data`/`rsp_err` carry the captured values.
  - `ss_n[g]` stays low for CS_HOLD cycles, then go to GAP.
- GAP: all `ss_n` high for CS_GAP cycles, then go to IDLE.
- Requests arriving mid-transaction are not accepted until IDLE. `req_valid` may change freely while not granted.
- A requester that drops `req_valid` before its grant is simply skipped.

## Timing
- Reset values:
  - `ss_n` all 1; `req_ready`, `rsp_valid`, `eng_start`, `busy`, `rsp_err` 0.
  - `rsp_data` and `eng_tx` 8'h00; `rr_ptr` 0; state IDLE.
- Reset asserted mid-transaction: on the next edge `ss_n` goes all high, any pending response is dropped, and no `rsp_valid` is issued.
- Grant is cycle T:
  - `ss_n[g]` falls at T+1.
  - `eng_start` is high at T+1+CS_SETUP.
  - `eng_done` arrives at cycle D; `rsp_valid` is high at D+1.
  - `ss_n[g]` rises at D+1+CS_HOLD.
  - The next grant is possible at D+1+CS_HOLD+CS_GAP.
- The earliest `eng_done` is START+1. Timeout fires if `eng_done` is not seen within TIMEOUT WAIT cycles.
- The same requester can be granted again after a transaction only if no other requester is valid.

## Structure
- Shared package `spi_pkg`:
  - State enumeration.
  - N_REQ.
  - Default CS_SETUP, CS_HOLD, CS_GAP and TIMEOUT constants.
- Sub-module `rr_arbiter`:
  - Combinational grant from `req_valid` and `rr_ptr`, producing a one-hot grant and a binary index.
  - Registered pointer update on an accept strobe.
- The top level holds the FSM, one shared down-counter reused for setup/hold/gap/timeout, and the data latches.

## Test plan
- Single request: `req_valid`=4'b0010 with byte 8'hA5, engine returns 8'h3C 5 cycles after start. Required: `req_ready`=4'b0010 at T, `ss_n`=4'b1101 from T+1, `eng_start` at T+3 with `eng_tx`=A5, `rsp_valid`=4'b0010 with `rsp_data`=3C and `rsp_err`=0.
- Contention: all four requests held continuously. Required: grant order 0,1,2,3,0; never two `ss_n` bits low at once; at least CS_GAP cycles with all selects high between transactions.
- Wrap and skip: `rr_ptr`=3, `req_valid`=4'b0101. Required: grant 0, then 2.
- Timeout: engine never asserts `eng_done`. Required: after 64 WAIT cycles, `rsp_valid` pulses with `rsp_err`=1 and `rsp_data`=00, and selects deassert normally.
- Reset mid-WAIT: assert `rst` for 1 cycle. Required: next edge shows `ss_n`=4'b1111, `busy`=0, no `rsp_valid`, and the next grant starts from requester 0.
- Stray `eng_done` while in SETUP: required to be ignored; the transaction completes on the later real `eng_done`.
